// File: rtl/micro_sequencer_pkg.sv
// Shared types and constants for the micro-sequencer: micro-type encodings,
// sequencer states, dispatch sentinel and micro-instruction field positions.
package micro_sequencer_pkg;

  // Micro-type field encodings (minstr[43:41]); 110 is a spare sequential type
  typedef enum logic [2:0] {
    MT_SEQ   = 3'b000,
    MT_IMM0  = 3'b001,
    MT_IMM1  = 3'b010,
    MT_CBR   = 3'b011,
    MT_BR    = 3'b100,
    MT_MWAIT = 3'b101,
    MT_SEQ2  = 3'b110,
    MT_END   = 3'b111
  } mtype_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MWAIT = 2'd2
  } seq_state_e;

  // Dispatch entry marking an opcode with no micro-routine
  localparam logic [7:0] DISPATCH_ILLEGAL = 8'hFF;

  localparam int unsigned MT_FIELD_W = 3;
  localparam int unsigned TGT_LSB    = 10;

endpackage

// File: rtl/micro_sequencer_dispatch.sv
// micro_dispatch_rom: combinational opcode -> micro-ROM start address table.
// Opcode n maps to n*8; opcodes 28..31 have no routine and map to the
// illegal sentinel.
module micro_dispatch_rom
  import micro_sequencer_pkg::*;
#(
  parameter int unsigned UPC_W = 8,
  parameter int unsigned OP_W  = 5
) (
  input  logic [OP_W-1:0]  opcode_i,
  output logic [UPC_W-1:0] entry_o
);

  // Table lookup; anything not listed is illegal
  always_comb begin
    entry_o = UPC_W'(DISPATCH_ILLEGAL);
    case (opcode_i)
      5'd0:  entry_o = UPC_W'(8'h00);  5'd1:  entry_o = UPC_W'(8'h08);
      5'd2:  entry_o = UPC_W'(8'h10);  5'd3:  entry_o = UPC_W'(8'h18);
      5'd4:  entry_o = UPC_W'(8'h20);  5'd5:  entry_o = UPC_W'(8'h28);
      5'd6:  entry_o = UPC_W'(8'h30);  5'd7:  entry_o = UPC_W'(8'h38);
      5'd8:  entry_o = UPC_W'(8'h40);  5'd9:  entry_o = UPC_W'(8'h48);
      5'd10: entry_o = UPC_W'(8'h50);  5'd11: entry_o = UPC_W'(8'h58);
      5'd12: entry_o = UPC_W'(8'h60);  5'd13: entry_o = UPC_W'(8'h68);
      5'd14: entry_o = UPC_W'(8'h70);  5'd15: entry_o = UPC_W'(8'h78);
      5'd16: entry_o = UPC_W'(8'h80);  5'd17: entry_o = UPC_W'(8'h88);
      5'd18: entry_o = UPC_W'(8'h90);  5'd19: entry_o = UPC_W'(8'h98);
      5'd20: entry_o = UPC_W'(8'hA0);  5'd21: entry_o = UPC_W'(8'hA8);
      5'd22: entry_o = UPC_W'(8'hB0);  5'd23: entry_o = UPC_W'(8'hB8);
      5'd24: entry_o = UPC_W'(8'hC0);  5'd25: entry_o = UPC_W'(8'hC8);
      5'd26: entry_o = UPC_W'(8'hD0);  5'd27: entry_o = UPC_W'(8'hD8);
      default: entry_o = UPC_W'(DISPATCH_ILLEGAL);
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: dispatches macro opcodes to micro-routines and steps the
// micro-PC through them (sequential, branch, conditional branch, memory wait,
// end). Optional macro UCPU_MBRANCH_COND_EN makes type-011 branches depend on
// flag_z_i; without it they always branch.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int unsigned UPC_W   = 8,
  parameter int unsigned OP_W    = 5,
  parameter int unsigned MINST_W = 44
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic [OP_W-1:0]    opcode_i,
  output logic [UPC_W-1:0]   upc_o,
  input  logic [MINST_W-1:0] minstr_i,
  output logic               minstr_valid_o,
  input  logic               flag_z_i,
  input  logic               mem_done_i,
  output logic               busy_o,
  output logic               fault_o
);

  seq_state_e       state_q;
  logic [UPC_W-1:0] upc_q;
  logic             fault_q;

  logic [UPC_W-1:0] disp_entry;
  mtype_e           mtype;
  logic [UPC_W-1:0] target;
  logic [UPC_W-1:0] upc_inc;
  logic             upc_at_max;
  logic             cbr_taken;
  logic             unused_minstr;

  micro_dispatch_rom #(
    .UPC_W (UPC_W),
    .OP_W  (OP_W)
  ) u_dispatch (
    .opcode_i (opcode_i),
    .entry_o  (disp_entry)
  );

  assign mtype      = mtype_e'(minstr_i[MINST_W-1 -: MT_FIELD_W]);
  assign target     = minstr_i[TGT_LSB +: UPC_W];
  assign upc_inc    = upc_q + UPC_W'(1);
  assign upc_at_max = (upc_q == '1);

  assign unused_minstr = ^{minstr_i[MINST_W-MT_FIELD_W-1:TGT_LSB+UPC_W],
                           minstr_i[TGT_LSB-1:0]};

`ifdef UCPU_MBRANCH_COND_EN
  assign cbr_taken = flag_z_i;
`else
  logic unused_flag_z;
  assign unused_flag_z = flag_z_i;
  assign cbr_taken     = 1'b1;
`endif

  // Sequencer FSM: micro-PC stepping, wait handling and fault pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      upc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (instr_valid_i) begin
            if (disp_entry == UPC_W'(DISPATCH_ILLEGAL)) begin
              fault_q <= 1'b1;
            end else begin
              upc_q   <= disp_entry;
              state_q <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          // mem_done_i is deliberately not looked at here: a wait always
          // starts fresh in MWAIT
          if (mtype == MT_BR || (mtype == MT_CBR && cbr_taken)) begin
            upc_q <= target;
          end else if (mtype == MT_MWAIT) begin
            state_q <= ST_MWAIT;
          end else if (mtype == MT_END) begin
            upc_q   <= '0;
            state_q <= ST_IDLE;
          end else if (upc_at_max) begin
            upc_q   <= '0;
            fault_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            upc_q <= upc_inc;
          end
        end
        ST_MWAIT: begin
          if (mem_done_i) begin
            if (upc_at_max) begin
              upc_q   <= '0;
              fault_q <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              upc_q   <= upc_inc;
              state_q <= ST_EXEC;
            end
          end
        end
        default: begin
          upc_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready_o  = (state_q == ST_IDLE);
  assign busy_o         = (state_q != ST_IDLE);
  assign minstr_valid_o = (state_q == ST_EXEC);
  assign upc_o          = upc_q;
  assign fault_o        = fault_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: the bench plays the micro-ROM,
// stimulus pushes expected issues/faults, a negedge monitor pops and checks.
module tb_micro_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid_i = 1'b0;
  logic [4:0]  opcode_i = '0;
  logic        flag_z_i = 1'b0;
  logic        mem_done_i = 1'b0;
  logic        instr_ready_o;
  logic [7:0]  upc_o;
  logic [43:0] minstr_i;
  logic        minstr_valid_o;
  logic        busy_o;
  logic        fault_o;

  logic [43:0] rom [256];

  typedef struct packed {
    logic       is_fault;
    logic [7:0] upc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  int   cnt;

  micro_sequencer #(
    .UPC_W   (8),
    .OP_W    (5),
    .MINST_W (44)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_valid_i  (instr_valid_i),
    .instr_ready_o  (instr_ready_o),
    .opcode_i       (opcode_i),
    .upc_o          (upc_o),
    .minstr_i       (minstr_i),
    .minstr_valid_o (minstr_valid_o),
    .flag_z_i       (flag_z_i),
    .mem_done_i     (mem_done_i),
    .busy_o         (busy_o),
    .fault_o        (fault_o)
  );

  always #5 clk = ~clk;

  assign minstr_i = rom[upc_o];

  function automatic logic [43:0] mk(input logic [2:0] t, input logic [7:0] tgt);
    return {t, 23'd0, tgt, 10'd0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_issue(input logic [7:0] u);
    exp_q.push_back('{is_fault: 1'b0, upc: u});
  endtask

  task automatic push_fault();
    exp_q.push_back('{is_fault: 1'b1, upc: 8'h00});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op);
    int n = 0;
    while (!instr_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (!instr_ready_o) check("ready_timeout", instr_ready_o, 1);
    instr_valid_i = 1'b1;
    opcode_i      = op;
    tick();
    instr_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 50) begin
      tick();
      n++;
    end
    check("idle_reached", busy_o, 0);
  endtask

  // Monitor: every issue or fault pulse must match the head of the queue
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (fault_o || minstr_valid_o)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got fault=%0b valid=%0b upc=%0h, expected no output",
                 fault_o, minstr_valid_o, upc_o);
      end else begin
        e = exp_q.pop_front();
        check("sb_kind_fault", fault_o, e.is_fault);
        if (!e.is_fault) check("sb_upc", upc_o, e.upc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = mk(3'b111, 8'h00);
    rom[8'h10] = mk(3'b000, 8'h00);
    rom[8'h11] = mk(3'b001, 8'h00);
    rom[8'h12] = mk(3'b111, 8'h00);
    rom[8'h18] = mk(3'b100, 8'h40);
    rom[8'h40] = mk(3'b111, 8'h00);
    rom[8'h20] = mk(3'b101, 8'h00);
    rom[8'h21] = mk(3'b010, 8'h00);
    rom[8'h22] = mk(3'b111, 8'h00);
    rom[8'h28] = mk(3'b011, 8'h48);
    rom[8'h29] = mk(3'b111, 8'h00);
    rom[8'h48] = mk(3'b111, 8'h00);
    rom[8'h30] = mk(3'b100, 8'hFE);
    rom[8'hFE] = mk(3'b110, 8'h00);
    rom[8'hFF] = mk(3'b000, 8'h00);
    rom[8'h38] = mk(3'b101, 8'h00);
    rom[8'h39] = mk(3'b111, 8'h00);

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_upc", upc_o, 0);
    check("rst_valid", minstr_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_ready", instr_ready_o, 1);
    mon_en = 1'b1;

    // Three-step routine; a stray valid during EXEC must be ignored
    push_issue(8'h10); push_issue(8'h11); push_issue(8'h12);
    issue(5'd2);
    instr_valid_i = 1'b1;
    opcode_i      = 5'd3;
    tick(); tick(); tick();
    instr_valid_i = 1'b0;
    check("seq_end_ready", instr_ready_o, 1);
    check("seq_end_upc", upc_o, 0);
    check("seq_end_busy", busy_o, 0);

    // Unconditional branch
    push_issue(8'h18); push_issue(8'h40);
    issue(5'd3);
    wait_idle();

    // Conditional branch, flag clear
    flag_z_i = 1'b0;
    push_issue(8'h28);
`ifdef UCPU_MBRANCH_COND_EN
    push_issue(8'h29);
`else
    push_issue(8'h48);
`endif
    issue(5'd5);
    wait_idle();

    // Conditional branch, flag set
    flag_z_i = 1'b1;
    push_issue(8'h28); push_issue(8'h48);
    issue(5'd5);
    wait_idle();
    flag_z_i = 1'b0;

    // Memory wait: done held low 4 cycles then pulsed
    push_issue(8'h20); push_issue(8'h21); push_issue(8'h22);
    issue(5'd4);
    cnt = 0;
    tick();
    while (busy_o && !minstr_valid_o && cnt < 20) begin
      cnt++;
      if (cnt == 5) mem_done_i = 1'b1;
      tick();
      mem_done_i = 1'b0;
    end
    check("mwait_latency", cnt, 5);
    wait_idle();

    // mem_done in the same cycle as the wait issue is ignored
    push_issue(8'h38); push_issue(8'h39);
    issue(5'd7);
    mem_done_i = 1'b1;
    tick();
    mem_done_i = 1'b0;
    check("early_done_valid", minstr_valid_o, 0);
    check("early_done_busy", busy_o, 1);
    check("early_done_upc", upc_o, 8'h38);
    tick();
    mem_done_i = 1'b1;
    tick();
    mem_done_i = 1'b0;
    wait_idle();

    // Illegal opcode
    push_fault();
    issue(5'd28);
    check("illegal_fault", fault_o, 1);
    check("illegal_busy", busy_o, 0);
    check("illegal_ready", instr_ready_o, 1);
    check("illegal_upc", upc_o, 0);
    tick();
    check("illegal_fault_clear", fault_o, 0);

    // Micro-PC overrun at 8'hFF
    push_issue(8'h30); push_issue(8'hFE); push_issue(8'hFF); push_fault();
    issue(5'd6);
    tick(); tick(); tick();
    check("overrun_fault", fault_o, 1);
    check("overrun_upc", upc_o, 0);
    check("overrun_busy", busy_o, 0);
    check("overrun_valid", minstr_valid_o, 0);
    tick();
    check("overrun_fault_clear", fault_o, 0);

    // Reset during MWAIT
    push_issue(8'h20);
    issue(5'd4);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_upc", upc_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_valid", minstr_valid_o, 0);
    check("midrst_fault", fault_o, 0);
    check("midrst_ready", instr_ready_o, 1);
    push_issue(8'h10); push_issue(8'h11); push_issue(8'h12);
    issue(5'd2);
    wait_idle();

    repeat (3) tick();
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
